dmem_ctrl: RTL and testbench

Data-memory access controller between the DLX pipeline MEM stage and the word-addressed `sram` data memory. Accepts byte/halfword/word load and store requests from the pipeline. Loads return big-endian lane extraction with sign or zero extension. Sub-word stores become read-modify-write word sequences, because `sram` stores only whole 32-bit words at exact, word-aligned addresses.

---
 rtl/dlx_mem_pkg.sv | 35 +++
 rtl/dmem_lane_align.sv | 63 ++++++
 rtl/dmem_ctrl.sv | 144 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data-memory controller: access-size
// encodings, byte-lane offsets, controller FSM states and the alignment check.
package dlx_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Big-endian byte offsets within a word: offset 0 is bits [31:24].
   localparam logic [1:0] OFF_B0 = 2'd0;
   localparam logic [1:0] OFF_B1 = 2'd1;
   localparam logic [1:0] OFF_B2 = 2'd2;
   localparam logic [1:0] OFF_B3 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_WR     = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_RESP   = 3'd5
   } state_t;

   // A halfword needs an even address, a word (size 10 or 11) a multiple of 4.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for dmem_ctrl: extracts and extends load
// data from a memory word, and merges sub-word store data into an old word.
// Low offset bits that do not apply to the access size are ignored.
import dlx_mem_pkg::*;

module dmem_lane_align (
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_signed,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane extraction, extension and store merge for the selected size.
   always_comb begin
      byte_sel   = 8'h00;
      half_sel   = 16'h0000;
      load_data  = old_word;
      merge_data = old_word;
      case (offset)
         OFF_B0:  byte_sel = old_word[31:24];
         OFF_B1:  byte_sel = old_word[23:16];
         OFF_B2:  byte_sel = old_word[15:8];
         OFF_B3:  byte_sel = old_word[7:0];
         default: byte_sel = old_word[7:0];
      endcase
      if (offset[1]) begin
         half_sel = old_word[15:0];
      end else begin
         half_sel = old_word[31:16];
      end
      case (size)
         SZ_BYTE: begin
            load_data = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
            case (offset)
               OFF_B0:  merge_data = {wdata[7:0], old_word[23:0]};
               OFF_B1:  merge_data = {old_word[31:24], wdata[7:0], old_word[15:0]};
               OFF_B2:  merge_data = {old_word[31:16], wdata[7:0], old_word[7:0]};
               OFF_B3:  merge_data = {old_word[31:8], wdata[7:0]};
               default: merge_data = old_word;
            endcase
         end
         SZ_HALF: begin
            load_data = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
            if (offset[1]) begin
               merge_data = {old_word[31:16], wdata[15:0]};
            end else begin
               merge_data = {wdata[15:0], old_word[15:0]};
            end
         end
         default: begin
            load_data  = old_word;
            merge_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// DLX MEM-stage data-memory controller driving a word-addressed sram.
// Sub-word stores become read-modify-write sequences; loads are formatted
// big-endian with sign/zero extension. Optional feature macro:
// DMEM_MISALIGN_TRAP_EN - misaligned halfword/word requests skip memory and
// respond next cycle with misalign_err; otherwise low address bits are masked.
import dlx_mem_pkg::*;

module dmem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misalign_err,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   state_t      state;
   logic [1:0]  size_r;
   logic [1:0]  off_r;
   logic        signed_r;
   logic [31:0] wdata_r;
   logic [31:0] load_data;
   logic [31:0] merge_data;
   logic        accept;
   logic        trap;

   assign req_ready = !rst && ((state == ST_IDLE) || (state == ST_RESP));
   assign accept    = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   dmem_lane_align u_align (
      .size       (size_r),
      .offset     (off_r),
      .is_signed  (signed_r),
      .old_word   (mem_dout),
      .wdata      (wdata_r),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Controller FSM with registered sram strobes and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         size_r       <= SZ_BYTE;
         off_r        <= 2'b00;
         signed_r     <= 1'b0;
         wdata_r      <= 32'h0000_0000;
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'h0000_0000;
         misalign_err <= 1'b0;
         mem_cs       <= 1'b0;
         mem_oe       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= 32'h0000_0000;
      end else begin
         // Strobes and response are single-cycle unless a state raises them.
         resp_valid   <= 1'b0;
         misalign_err <= 1'b0;
         mem_cs       <= 1'b0;
         mem_oe       <= 1'b0;
         mem_we       <= 1'b0;
         case (state)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  size_r   <= req_size;
                  off_r    <= req_addr[1:0];
                  signed_r <= req_signed;
                  wdata_r  <= req_wdata;
                  if (trap) begin
                     state        <= ST_RESP;
                     resp_valid   <= 1'b1;
                     misalign_err <= 1'b1;
                     resp_rdata   <= 32'h0000_0000;
                  end else if (!req_we) begin
                     state    <= ST_RD;
                     mem_cs   <= 1'b1;
                     mem_oe   <= 1'b1;
                     mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                  end else if (req_size[1]) begin
                     state    <= ST_WR;
                     mem_cs   <= 1'b1;
                     mem_we   <= 1'b1;
                     mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_din  <= req_wdata;
                  end else begin
                     state    <= ST_RMW_RD;
                     mem_cs   <= 1'b1;
                     mem_oe   <= 1'b1;
                     mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RD: begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_rdata <= load_data;
            end
            ST_WR: begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_rdata <= 32'h0000_0000;
            end
            ST_RMW_RD: begin
               state   <= ST_RMW_WR;
               mem_cs  <= 1'b1;
               mem_we  <= 1'b1;
               mem_din <= merge_data;
            end
            ST_RMW_WR: begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_rdata <= 32'h0000_0000;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: the driver pushes expected responses,
// a negedge monitor pops and compares them, including response cycle.
module tb_dmem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign_err;
   logic        mem_cs;
   logic        mem_oe;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mem [0:1023];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          we_cnt = 0;
   int          cs_cnt = 0;
   logic        we_prev = 1'b0;

   dmem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err),
      .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // sram model: combinational read while enabled, word write on the clock.
   assign mem_dout = (mem_cs && mem_oe) ? mem[mem_addr[11:2]] : 32'h0000_0000;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (mem_cs && mem_we) mem[mem_addr[11:2]] = mem_din;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Monitor: strobe sanity and scoreboard comparison of every response.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (mem_cs) begin
            cs_cnt++;
            check("addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
         end
         if (mem_we) begin
            we_cnt++;
            check("we_gap", {31'd0, we_prev}, 32'd0);
         end
         we_prev = mem_we;
         if (misalign_err && !resp_valid) check("err_without_resp", 32'd1, 32'd0);
         if (resp_valid) begin
            if (sbq.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("resp_rdata", resp_rdata, e.rdata);
               check("resp_err", {31'd0, misalign_err}, {31'd0, e.err});
               check("resp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Issue one request from a negedge; expected response arrives lat cycles after acceptance.
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
      int   n;
      exp_t e;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("ready_timeout", 32'd0, 32'd1);
      end else begin
         req_valid  = 1'b1;
         req_we     = we;
         req_size   = size;
         req_signed = sgn;
         req_addr   = addr;
         req_wdata  = wdata;
         e.rdata = exp_rd;
         e.err   = exp_err;
         e.cyc   = cyc + lat;
         sbq.push_back(e);
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", sbq.size(), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int we0;
      int cs0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
      mem[32'h200 >> 2] = 32'h1122_3344;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rst        = 1'b1;
      #3;
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_misalign", {31'd0, misalign_err}, 32'd0);
      check("rst_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_din", mem_din, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);
      @(negedge clk);

      // Word store then word load at 0x100.
      we0 = we_cnt;
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
      drain();
      check("word_store_we_cycles", we_cnt - we0, 32'd1);
      check("mem_100", mem[32'h100 >> 2], 32'hDEAD_BEEF);

      // Byte and halfword traffic around 0x200.
      issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h0000_0044, 1'b0, 2);
      issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 1'b0, 3);
      drain();
      check("mem_200_half", mem[32'h200 >> 2], 32'h1122_ABCD);
      issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'hFFFF_FFCD, 1'b0, 2);
      issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h0000_0080, 32'h0, 1'b0, 3);
      issue(1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
      issue(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 32'h0000_0080, 1'b0, 2);
      issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'hFFFF_ABCD, 1'b0, 2);
      issue(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h0000_8022, 1'b0, 2);
      issue(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 32'h8022_ABCD, 1'b0, 2);
      drain();
      check("mem_200_byte", mem[32'h200 >> 2], 32'h8022_ABCD);

      // Back-to-back word stores to one address, then read back.
      issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h5, 32'h0, 1'b0, 2);
      issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h6, 32'h0, 1'b0, 2);
      issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h6, 1'b0, 2);
      drain();

      // Misaligned word load.
      cs0 = cs_cnt;
`ifdef DMEM_MISALIGN_TRAP_EN
      issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
      drain();
      check("trap_no_cs", cs_cnt - cs0, 32'd0);
`else
      issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
      drain();
      check("mask_one_cs", cs_cnt - cs0, 32'd1);
`endif

      // Reset during RMW_RD drops the request and leaves memory unchanged.
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_size   = 2'b01;
      req_signed = 1'b0;
      req_addr   = 32'h200;
      req_wdata  = 32'h0000_1234;
      @(posedge clk);
      #2;
      check("rmw_rd_cs", {31'd0, mem_cs}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
      check("midrst_resp", {31'd0, resp_valid}, 32'd0);
      check("midrst_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_midrst", {31'd0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      check("mem_200_untouched", mem[32'h200 >> 2], 32'h8022_ABCD);
      check("no_pending", sbq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
